// File: rtl/dlatch_bank.sv
// Clocked bank of gated latch channels with per-channel gates and a snapshot serial scan-out.
// Optional change-detect pulses on chg are built only when DLATCH_BANK_CHG_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no scan in progress; scan_start takes a snapshot of q
// S_SHIFT | snapshot shifting out LSB first, one bit per cycle
module dlatch_bank #(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter bit EN_ACTIVE_LOW = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       en,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS*WIDTH-1:0] q_n,
    input  logic                      scan_start,
    output logic                      scan_busy,
    output logic                      scan_out,
    output logic                      scan_done
`ifdef DLATCH_BANK_CHG_EN
    ,
    output logic [CHANNELS-1:0]       chg
`endif
);

    localparam int N     = CHANNELS * WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N-1:0]      q_reg;
    logic [N-1:0]      shadow;
    logic [CNT_W-1:0]  cnt;
    logic [CHANNELS-1:0] gate;
    logic              start_acc;
    logic              shift_last;

    assign gate = EN_ACTIVE_LOW ? ~en : en;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (gate[c]) begin
                    q_reg[c*WIDTH +: WIDTH] <= d[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    // q and q_n both come straight off q_reg so they can never disagree.
    assign q   = q_reg;
    assign q_n = ~q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_acc  = 1'b0;
        shift_last = 1'b0;
        case (state)
            S_IDLE: begin
                if (scan_start) begin
                    state_nxt = S_SHIFT;
                    start_acc = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt  = S_IDLE;
                    shift_last = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Snapshot takes the pre-capture q, so captures on the start edge are not in the stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            cnt       <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= shift_last;
            if (start_acc) begin
                shadow <= q_reg;
                cnt    <= '0;
            end else if (state == S_SHIFT) begin
                shadow <= shadow >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

    assign scan_busy = (state == S_SHIFT);
    assign scan_out  = (state == S_SHIFT) & shadow[0];

`ifdef DLATCH_BANK_CHG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chg <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                chg[c] <= gate[c] && (d[c*WIDTH +: WIDTH] != q_reg[c*WIDTH +: WIDTH]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dlatch_bank.sv
// Self-checking bench for dlatch_bank: both gate polarities side by side, vector table for
// capture behaviour, queue scoreboard for the serial scan stream and its corner cases.
module tb_dlatch_bank;

    logic        clk;
    logic        rst;
    logic [31:0] d;
    logic [3:0]  en;
    logic        scan_start;
    logic [31:0] q0, q_n0, q1, q_n1;
    logic        busy0, out0, done0, busy1, out1, done1;
`ifdef DLATCH_BANK_CHG_EN
    logic [3:0]  chg0, chg1;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  en;
        logic [31:0] d;
        logic [31:0] q0;
        logic [31:0] q1;
    } vec_t;

    vec_t        vecs[6];
    logic [63:0] sb_q[$];
    logic        sb_bit[$];

    dlatch_bank #(.WIDTH(8), .CHANNELS(4), .EN_ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .d(d), .en(en), .q(q0), .q_n(q_n0),
        .scan_start(scan_start), .scan_busy(busy0), .scan_out(out0), .scan_done(done0)
`ifdef DLATCH_BANK_CHG_EN
        , .chg(chg0)
`endif
    );

    dlatch_bank #(.WIDTH(8), .CHANNELS(4), .EN_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .d(d), .en(en), .q(q1), .q_n(q_n1),
        .scan_start(scan_start), .scan_busy(busy1), .scan_out(out1), .scan_done(done1)
`ifdef DLATCH_BANK_CHG_EN
        , .chg(chg1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called in the first cycle after scan_start was sampled; returns in the done cycle.
    task automatic collect_scan(input logic [31:0] pat, input int drop_at, input bit scramble,
                                output int nbusy);
        for (int i = 0; i < 32; i++) sb_bit.push_back(pat[i]);
        nbusy = 0;
        check("scan_enter_busy", busy0, 1'b1);
        while (busy0 && nbusy < 40) begin
            if (sb_bit.size() > 0) check("scan_bit", out0, sb_bit.pop_front());
            if (nbusy == drop_at) scan_start = 1'b0;
            if (scramble) begin
                d  = $urandom;
                en = 4'($urandom);
            end
            nbusy++;
            tick();
        end
        check("scan_len", nbusy, 32);
        check("scan_bits_left", sb_bit.size(), 0);
        check("scan_done_pulse", done0, 1'b1);
        check("scan_out_idle", out0, 1'b0);
        sb_bit.delete();
    endtask

    logic [63:0] e;
    logic [31:0] e32;
    int          nb;

    initial begin
        rst = 1'b1; d = '0; en = '0; scan_start = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            d = $urandom; en = 4'($urandom); scan_start = 1'($urandom_range(0, 1));
            tick();
            check("rst_q0", q0, 32'h0);
            check("rst_qn0", q_n0, 32'hFFFF_FFFF);
            check("rst_q1", q1, 32'h0);
            check("rst_busy", busy0, 1'b0);
            check("rst_out", out0, 1'b0);
            check("rst_done", done0, 1'b0);
`ifdef DLATCH_BANK_CHG_EN
            check("rst_chg", chg0, 4'h0);
`endif
        end
        scan_start = 1'b0;

        // capture vectors; q0 is active-high gate, q1 active-low, state carries row to row
        vecs[0] = '{1'b0, 4'b0101, 32'hA5A5_A5A5, 32'h00A5_00A5, 32'hA500_A500};
        vecs[1] = '{1'b0, 4'b0000, 32'h1234_5678, 32'h00A5_00A5, 32'h1234_5678};
        vecs[2] = '{1'b0, 4'b1111, 32'hFFFF_0000, 32'hFFFF_0000, 32'h1234_5678};
        vecs[3] = '{1'b0, 4'b1000, 32'h1122_3344, 32'h11FF_0000, 32'h1222_3344};
        vecs[4] = '{1'b0, 4'b0010, 32'hAABB_CCDD, 32'h11FF_CC00, 32'hAABB_33DD};
        vecs[5] = '{1'b1, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            rst = vecs[i].rst; en = vecs[i].en; d = vecs[i].d;
            sb_q.push_back({vecs[i].q0, vecs[i].q1});
            tick();
            e = sb_q.pop_front();
            check("vec_q0", q0, e[63:32]);
            e32 = ~e[63:32];
            check("vec_qn0", q_n0, e32);
            check("vec_q1", q1, e[31:0]);
            e32 = ~e[31:0];
            check("vec_qn1", q_n1, e32);
        end

        // scan of a single-snapshot pattern with traffic on d/en during the shift
        rst = 1'b0; en = 4'hF; d = 32'h8000_0001;
        tick();
        check("scan_load_q", q0, 32'h8000_0001);
        scan_start = 1'b1; d = 32'h0;
        tick();
        check("scan_start_capture", q0, 32'h0);
        collect_scan(32'h8000_0001, 0, 1'b1, nb);
        tick();
        check("scan_done_one_cycle", done0, 1'b0);

        // scan_start held: back-to-back scans, start during shift not queued
        en = 4'hF; d = 32'h0000_F00F; scan_start = 1'b0;
        tick();
        en = 4'h0; scan_start = 1'b1;
        tick();
        collect_scan(32'h0000_F00F, -1, 1'b0, nb);
        tick();
        collect_scan(32'h0000_F00F, 5, 1'b0, nb);
        tick();
        check("no_queued_scan", busy0, 1'b0);
        check("no_queued_done", done0, 1'b0);

        // reset aborts a scan mid-stream
        en = 4'hF; d = 32'hFFFF_FFFF;
        tick();
        en = 4'h0; scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("abort_pre_bit", out0, 1'b1);
            tick();
        end
        check("abort_busy_before", busy0, 1'b1);
        rst = 1'b1;
        tick();
        check("abort_busy", busy0, 1'b0);
        check("abort_out", out0, 1'b0);
        check("abort_done", done0, 1'b0);
        check("abort_q", q0, 32'h0);
        check("abort_qn", q_n0, 32'hFFFF_FFFF);
        rst = 1'b0;
        tick();
        check("abort_no_done", done0, 1'b0);
        check("abort_stay_idle", busy0, 1'b0);

`ifdef DLATCH_BANK_CHG_EN
        en = 4'b0100; d = 32'h0;
        tick();
        check("chg_same", chg0, 4'h0);
        d = 32'h00AB_0000;
        tick();
        check("chg_diff", chg0, 4'b0100);
        check("chg_q", q0, 32'h00AB_0000);
        tick();
        check("chg_pulse_end", chg0, 4'h0);
        en = 4'h0; d = 32'h1111_1111;
        tick();
        check("chg_gate_off", chg0, 4'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
